// File: rtl/fpu_exc_handler.sv
// FP32 multiplier exception stage: special-value substitution, sticky flags, interrupt and event counter.
// Optional event counter enabled by defining FPU_EXC_COUNT_EN; otherwise exc_count is tied to zero.
module fpu_exc_handler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [31:0]      in_result,
    input  logic             invalid_flag,
    input  logic             overflow_flag,
    input  logic             zero_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags,
    output logic [2:0]       sticky_flags,
    input  logic [2:0]       irq_mask,
    input  logic             clr_sticky,
    output logic             irq,
    output logic [CNT_W-1:0] exc_count
);

    // Valid/ready: a transfer happens on a rising edge where valid && ready; the producer holds
    // its payload stable while valid is high and ready is low. The single output register
    // refills in the same cycle it drains, so in_ready depends only on out_valid and out_ready.
    logic        accept;
    logic [2:0]  flags_d;
    logic [31:0] result_d;
    logic [2:0]  sticky_d;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        flags_d  = 3'b000;
        result_d = in_result;
        if (invalid_flag) begin
            flags_d  = 3'b100;
            result_d = 32'h7FC0_0000;
        end else if (overflow_flag) begin
            flags_d  = 3'b010;
            result_d = {in_sign, 8'hFF, 23'h0};
        end else if (zero_flag) begin
            flags_d  = 3'b001;
            result_d = {in_sign, 31'h0};
        end
    end

    // A same-cycle acceptance overrides the clear so its flags are never lost.
    always_comb begin
        sticky_d = sticky_flags;
        if (accept) begin
            sticky_d = clr_sticky ? flags_d : (sticky_flags | flags_d);
        end else if (clr_sticky) begin
            sticky_d = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_result   <= 32'h0;
            out_flags    <= 3'b000;
            sticky_flags <= 3'b000;
            irq          <= 1'b0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_result <= result_d;
                out_flags  <= flags_d;
            end else if (out_valid && out_ready) begin
                out_valid  <= 1'b0;
            end
            sticky_flags <= sticky_d;
            irq          <= |(sticky_d & irq_mask);
        end
    end

`ifdef FPU_EXC_COUNT_EN
    logic [CNT_W-1:0] count_q;
    logic             flagged_accept;

    assign flagged_accept = accept && (|flags_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_sticky) begin
            count_q <= flagged_accept ? CNT_W'(1) : '0;
        end else if (flagged_accept && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign exc_count = count_q;
`else
    assign exc_count = '0;
`endif

endmodule
